// File: rtl/monkey_action_ctrl_if.sv
// ---------------------------------------------------------------------------
// monkey_action_ctrl_if
// Bundle between the keyboard/collision side and the monkey mover, as seen by
// the action controller.
//   leftPressed..downPressed  raw key levels from the keyboard
//   onRope, onLedge           footing flags from collision logic
//   enemyHit                  monkey touched an enemy/fruit (level)
//   topLeftY                  signed monkey Y position reported by the mover
//   leftOut..downOut          gated key requests into the mover
//   moveResetN                active-low reset pulse into the mover
// slave  = the controller (consumes keys/status, drives gated keys)
// master = the surrounding game logic / testbench
// ---------------------------------------------------------------------------
interface monkey_action_ctrl_if;
  logic               leftPressed;
  logic               rightPressed;
  logic               upPressed;
  logic               downPressed;
  logic               onRope;
  logic               onLedge;
  logic               enemyHit;
  logic signed [10:0] topLeftY;
  logic               leftOut;
  logic               rightOut;
  logic               upOut;
  logic               downOut;
  logic               moveResetN;

  modport master (
    output leftPressed, rightPressed, upPressed, downPressed,
    output onRope, onLedge, enemyHit, topLeftY,
    input  leftOut, rightOut, upOut, downOut, moveResetN
  );

  modport slave (
    input  leftPressed, rightPressed, upPressed, downPressed,
    input  onRope, onLedge, enemyHit, topLeftY,
    output leftOut, rightOut, upOut, downOut, moveResetN
  );
endinterface

// File: rtl/monkey_action_ctrl.sv
// ---------------------------------------------------------------------------
// monkey_action_ctrl
// Sequencing FSM in front of the monkey mover. Gates key requests per action
// state (grounded / airborne / climbing), converts the up key into a
// fixed-length jump pulse, and runs the death -> respawn / game-over flow.
// All timing is counted in startOfFrame pulses.
// Ports:
//   clk, resetN    clock, asynchronous active-low reset
//   startOfFrame   one-clk pulse per video frame
//   gameEnable     level, game running
//   mover          monkey_action_ctrl_if.slave (keys, footing, hit, Y, gated
//                  keys, moveResetN)
//   state          IDLE=0 GROUND=1 AIR=2 CLIMB=3 DYING=4 RESPAWN=5 OVER=6
//   livesLeft      remaining lives
//   dying          high while in DYING (sprite blink select)
//   gameOver       high while in OVER
// All outputs are registered from the next-state logic, so they line up with
// the state register and react one clock after the inputs.
// ---------------------------------------------------------------------------
module monkey_action_ctrl #(
  parameter int LIVES          = 3,
  parameter int DEATH_FRAMES   = 60,
  parameter int RESPAWN_FRAMES = 30,
  parameter int JUMP_FRAMES    = 2,
  parameter int FALL_Y         = 470
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic                    gameEnable,
  monkey_action_ctrl_if.slave     mover,
  output logic [2:0]              state,
  output logic [1:0]              livesLeft,
  output logic                    dying,
  output logic                    gameOver
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] GROUND  = 3'd1;
  localparam logic [2:0] AIR     = 3'd2;
  localparam logic [2:0] CLIMB   = 3'd3;
  localparam logic [2:0] DYING   = 3'd4;
  localparam logic [2:0] RESPAWN = 3'd5;
  localparam logic [2:0] OVER    = 3'd6;

  localparam int CNT_MAX = (DEATH_FRAMES > RESPAWN_FRAMES) ? DEATH_FRAMES : RESPAWN_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int JMP_W   = $clog2(JUMP_FRAMES + 1);

  logic [2:0]       nextState;
  logic [1:0]       nextLives;
  logic [CNT_W-1:0] frameCnt;
  logic [CNT_W-1:0] nextFrameCnt;
  logic [JMP_W-1:0] jumpCnt;
  logic [JMP_W-1:0] nextJumpCnt;
  logic             upPrev;
  logic             footing;
  logic             killed;
  logic             nextLeft;
  logic             nextRight;
  logic             nextUp;
  logic             nextDown;

  // Next-state, lives and frame counter. A frame pulse on the entry clock is
  // loaded into the freshly cleared counter so it is not lost.
  always_comb begin
    footing      = mover.onRope | mover.onLedge;
    killed       = mover.enemyHit | (mover.topLeftY > $signed(11'(FALL_Y)));
    nextState    = state;
    nextLives    = livesLeft;
    nextFrameCnt = frameCnt;
    case (state)
      IDLE: begin
        if (gameEnable) begin
          nextState = GROUND;
          nextLives = 2'(LIVES);
        end
      end
      GROUND, AIR, CLIMB: begin
        if (!gameEnable) begin
          nextState = IDLE;
        end else if (killed) begin
          // A hit outranks any footing change on the same clock.
          nextState    = DYING;
          nextLives    = (livesLeft == 2'd0) ? 2'd0 : livesLeft - 2'd1;
          nextFrameCnt = CNT_W'(startOfFrame);
        end else if (state == GROUND) begin
          if (mover.onRope && (mover.upPressed || mover.downPressed)) nextState = CLIMB;
          else if (!footing)                                         nextState = AIR;
        end else if (state == AIR) begin
          if (mover.onRope)       nextState = CLIMB;
          else if (mover.onLedge) nextState = GROUND;
        end else begin
          if (!mover.onRope && mover.onLedge) nextState = GROUND;
          else if (!footing)                  nextState = AIR;
        end
      end
      DYING: begin
        if (frameCnt == CNT_W'(DEATH_FRAMES)) begin
          nextState    = (livesLeft == 2'd0) ? OVER : RESPAWN;
          nextFrameCnt = CNT_W'(startOfFrame);
        end else if (startOfFrame) begin
          nextFrameCnt = frameCnt + 1'b1;
        end
      end
      RESPAWN: begin
        if (frameCnt == CNT_W'(RESPAWN_FRAMES)) nextState    = GROUND;
        else if (startOfFrame)                  nextFrameCnt = frameCnt + 1'b1;
      end
      OVER: begin
        if (!gameEnable) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Jump pulse: only a fresh press while staying grounded arms it; anything
  // that leaves GROUND drops the counter to zero.
  always_comb begin
    nextJumpCnt = '0;
    if (state == GROUND && nextState == GROUND) begin
      if (mover.upPressed && !upPrev)          nextJumpCnt = JMP_W'(JUMP_FRAMES);
      else if (jumpCnt != '0 && startOfFrame)  nextJumpCnt = jumpCnt - 1'b1;
      else                                     nextJumpCnt = jumpCnt;
    end
  end

  // Key gating follows the state being entered so keys and state move together.
  always_comb begin
    nextLeft  = 1'b0;
    nextRight = 1'b0;
    nextUp    = 1'b0;
    nextDown  = 1'b0;
    case (nextState)
      GROUND: begin
        nextLeft  = mover.leftPressed;
        nextRight = mover.rightPressed;
        nextUp    = (nextJumpCnt != '0);
      end
      AIR: begin
        nextLeft  = mover.leftPressed;
        nextRight = mover.rightPressed;
      end
      CLIMB: begin
        nextLeft  = mover.leftPressed;
        nextRight = mover.rightPressed;
        nextUp    = mover.upPressed;
        nextDown  = mover.downPressed;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state            <= IDLE;
      livesLeft        <= 2'(LIVES);
      frameCnt         <= '0;
      jumpCnt          <= '0;
      upPrev           <= 1'b0;
      mover.leftOut    <= 1'b0;
      mover.rightOut   <= 1'b0;
      mover.upOut      <= 1'b0;
      mover.downOut    <= 1'b0;
      mover.moveResetN <= 1'b1;
      dying            <= 1'b0;
      gameOver         <= 1'b0;
    end else begin
      state            <= nextState;
      livesLeft        <= nextLives;
      frameCnt         <= nextFrameCnt;
      jumpCnt          <= nextJumpCnt;
      upPrev           <= mover.upPressed;
      mover.leftOut    <= nextLeft;
      mover.rightOut   <= nextRight;
      mover.upOut      <= nextUp;
      mover.downOut    <= nextDown;
      // Low only on the clock that enters RESPAWN.
      mover.moveResetN <= !(nextState == RESPAWN && state != RESPAWN);
      dying            <= (nextState == DYING);
      gameOver         <= (nextState == OVER);
    end
  end

endmodule

// File: tb/tb_monkey_action_ctrl.sv
// ---------------------------------------------------------------------------
// tb_monkey_action_ctrl
// Directed testbench for monkey_action_ctrl. Frames are 4 clocks long with
// startOfFrame in the first clock. Inputs change 1 time unit after a rising
// edge and outputs are read at the same point.
// ---------------------------------------------------------------------------
module tb_monkey_action_ctrl;

  logic       clk;
  logic       resetN;
  logic       startOfFrame;
  logic       gameEnable;
  logic [2:0] state;
  logic [1:0] livesLeft;
  logic       dying;
  logic       gameOver;
  int         checks;
  int         errors;

  monkey_action_ctrl_if bus();

  monkey_action_ctrl dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .gameEnable   (gameEnable),
    .mover        (bus),
    .state        (state),
    .livesLeft    (livesLeft),
    .dying        (dying),
    .gameOver     (gameOver)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frameEdge();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic runFrames(input int n);
    for (int i = 0; i < n; i++) begin
      frameEdge();
      tick();
      tick();
      tick();
    end
  endtask

  task automatic test_reset();
    checks++;
    if (state !== 3'd0 || livesLeft !== 2'd3) begin
      errors++;
      $display("[TB] FAIL reset_state: state=%0d lives=%0d expected state=0 lives=3", state, livesLeft);
    end
    checks++;
    if ({bus.leftOut, bus.rightOut, bus.upOut, bus.downOut, bus.moveResetN, dying, gameOver} !== 7'b0000100) begin
      errors++;
      $display("[TB] FAIL reset_outs: keys=%b mrN=%b dying=%b over=%b expected keys=0000 mrN=1 dying=0 over=0",
               {bus.leftOut, bus.rightOut, bus.upOut, bus.downOut}, bus.moveResetN, dying, gameOver);
    end
    @(posedge clk);
    #1;
    resetN      = 1'b1;
    bus.onLedge = 1'b1;
    gameEnable  = 1'b1;
    tick();
    checks++;
    if (state !== 3'd1 || livesLeft !== 2'd3) begin
      errors++;
      $display("[TB] FAIL start_ground: state=%0d lives=%0d expected state=1 lives=3", state, livesLeft);
    end
    checks++;
    if ({bus.leftOut, bus.rightOut, bus.upOut, bus.downOut, bus.moveResetN} !== 5'b00001) begin
      errors++;
      $display("[TB] FAIL start_outs: keys=%b mrN=%b expected keys=0000 mrN=1",
               {bus.leftOut, bus.rightOut, bus.upOut, bus.downOut}, bus.moveResetN);
    end
  endtask

  task automatic test_jump();
    bus.upPressed = 1'b1;
    tick();
    checks++;
    if (bus.upOut !== 1'b1) begin
      errors++;
      $display("[TB] FAIL jump_start: upOut=%b expected 1", bus.upOut);
    end
    runFrames(1);
    checks++;
    if (bus.upOut !== 1'b1) begin
      errors++;
      $display("[TB] FAIL jump_frame1: upOut=%b expected 1", bus.upOut);
    end
    runFrames(1);
    checks++;
    if (bus.upOut !== 1'b0) begin
      errors++;
      $display("[TB] FAIL jump_frame2: upOut=%b expected 0", bus.upOut);
    end
    runFrames(8);
    checks++;
    if (bus.upOut !== 1'b0 || state !== 3'd1) begin
      errors++;
      $display("[TB] FAIL jump_held: upOut=%b state=%0d expected upOut=0 state=1", bus.upOut, state);
    end
    bus.leftPressed = 1'b1;
    bus.downPressed = 1'b1;
    tick();
    checks++;
    if ({bus.leftOut, bus.downOut} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL ground_gate: left,down=%b expected 10", {bus.leftOut, bus.downOut});
    end
    bus.leftPressed = 1'b0;
    bus.downPressed = 1'b0;
    bus.upPressed   = 1'b0;
    tick();
  endtask

  task automatic test_climb();
    bus.onRope    = 1'b1;
    bus.upPressed = 1'b1;
    tick();
    checks++;
    if (state !== 3'd3 || bus.upOut !== 1'b1) begin
      errors++;
      $display("[TB] FAIL climb_enter: state=%0d upOut=%b expected state=3 upOut=1", state, bus.upOut);
    end
    bus.upPressed = 1'b0;
    tick();
    checks++;
    if (state !== 3'd3 || bus.upOut !== 1'b0) begin
      errors++;
      $display("[TB] FAIL climb_up_release: state=%0d upOut=%b expected state=3 upOut=0", state, bus.upOut);
    end
    bus.upPressed   = 1'b1;
    bus.downPressed = 1'b1;
    tick();
    checks++;
    if ({bus.upOut, bus.downOut} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL climb_pass: up,down=%b expected 11", {bus.upOut, bus.downOut});
    end
    bus.upPressed   = 1'b0;
    bus.downPressed = 1'b0;
    bus.onRope      = 1'b0;
    tick();
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("[TB] FAIL climb_exit: state=%0d expected 1", state);
    end
    bus.topLeftY = 11'sd470;
    tick();
    checks++;
    if (state !== 3'd1 || livesLeft !== 2'd3) begin
      errors++;
      $display("[TB] FAIL fall_boundary: state=%0d lives=%0d expected state=1 lives=3", state, livesLeft);
    end
    bus.topLeftY = 11'sd100;
    tick();
  endtask

  task automatic test_death_respawn();
    bus.enemyHit = 1'b1;
    tick();
    bus.enemyHit = 1'b0;
    checks++;
    if (state !== 3'd4 || livesLeft !== 2'd2 || dying !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hit_enter: state=%0d lives=%0d dying=%b expected 4 2 1", state, livesLeft, dying);
    end
    tick();
    bus.enemyHit = 1'b1;
    tick();
    bus.enemyHit = 1'b0;
    checks++;
    if (livesLeft !== 2'd2) begin
      errors++;
      $display("[TB] FAIL hit_in_dying: lives=%0d expected 2", livesLeft);
    end
    runFrames(59);
    checks++;
    if (state !== 3'd4) begin
      errors++;
      $display("[TB] FAIL dying_59: state=%0d expected 4", state);
    end
    frameEdge();
    checks++;
    if (dying !== 1'b1) begin
      errors++;
      $display("[TB] FAIL dying_60: dying=%b expected 1", dying);
    end
    tick();
    checks++;
    if (state !== 3'd5 || bus.moveResetN !== 1'b0 || dying !== 1'b0) begin
      errors++;
      $display("[TB] FAIL respawn_enter: state=%0d mrN=%b dying=%b expected 5 0 0", state, bus.moveResetN, dying);
    end
    tick();
    checks++;
    if (bus.moveResetN !== 1'b1) begin
      errors++;
      $display("[TB] FAIL respawn_pulse: mrN=%b expected 1", bus.moveResetN);
    end
    bus.leftPressed = 1'b1;
    tick();
    checks++;
    if (bus.leftOut !== 1'b0) begin
      errors++;
      $display("[TB] FAIL respawn_lockout: leftOut=%b expected 0", bus.leftOut);
    end
    runFrames(29);
    checks++;
    if (state !== 3'd5) begin
      errors++;
      $display("[TB] FAIL respawn_29: state=%0d expected 5", state);
    end
    frameEdge();
    tick();
    checks++;
    if (state !== 3'd1 || bus.leftOut !== 1'b1) begin
      errors++;
      $display("[TB] FAIL respawn_done: state=%0d leftOut=%b expected 1 1", state, bus.leftOut);
    end
    bus.leftPressed = 1'b0;
    tick();
  endtask

  task automatic test_game_over();
    gameEnable = 1'b0;
    tick();
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("[TB] FAIL disable_idle: state=%0d expected 0", state);
    end
    gameEnable = 1'b1;
    tick();
    checks++;
    if (state !== 3'd1 || livesLeft !== 2'd3) begin
      errors++;
      $display("[TB] FAIL restart: state=%0d lives=%0d expected 1 3", state, livesLeft);
    end
    for (int i = 0; i < 3; i++) begin
      bus.topLeftY = 11'sd471;
      tick();
      bus.topLeftY = 11'sd100;
      checks++;
      if (state !== 3'd4 || livesLeft !== 2'(2 - i)) begin
        errors++;
        $display("[TB] FAIL fall_%0d: state=%0d lives=%0d expected 4 %0d", i, state, livesLeft, 2 - i);
      end
      runFrames(60);
      if (i < 2) begin
        runFrames(30);
        checks++;
        if (state !== 3'd1) begin
          errors++;
          $display("[TB] FAIL fall_%0d_back: state=%0d expected 1", i, state);
        end
      end
    end
    checks++;
    if (state !== 3'd6 || gameOver !== 1'b1 || livesLeft !== 2'd0) begin
      errors++;
      $display("[TB] FAIL over: state=%0d over=%b lives=%0d expected 6 1 0", state, gameOver, livesLeft);
    end
    runFrames(2);
    gameEnable = 1'b0;
    tick();
    checks++;
    if (state !== 3'd0 || gameOver !== 1'b0) begin
      errors++;
      $display("[TB] FAIL over_exit: state=%0d over=%b expected 0 0", state, gameOver);
    end
  endtask

  task automatic test_hit_priority_reset();
    gameEnable  = 1'b1;
    bus.onLedge = 1'b1;
    tick();
    bus.onLedge   = 1'b0;
    bus.upPressed = 1'b1;
    tick();
    checks++;
    if (state !== 3'd2 || bus.upOut !== 1'b0) begin
      errors++;
      $display("[TB] FAIL air_enter: state=%0d upOut=%b expected 2 0", state, bus.upOut);
    end
    bus.upPressed = 1'b0;
    bus.enemyHit  = 1'b1;
    bus.onRope    = 1'b1;
    tick();
    bus.enemyHit = 1'b0;
    bus.onRope   = 1'b0;
    checks++;
    if (state !== 3'd4 || livesLeft !== 2'd2) begin
      errors++;
      $display("[TB] FAIL hit_beats_rope: state=%0d lives=%0d expected 4 2", state, livesLeft);
    end
    runFrames(10);
    #2;
    resetN = 1'b0;
    #1;
    checks++;
    if (state !== 3'd0 || livesLeft !== 2'd3 || dying !== 1'b0 || bus.moveResetN !== 1'b1) begin
      errors++;
      $display("[TB] FAIL async_reset: state=%0d lives=%0d dying=%b mrN=%b expected 0 3 0 1",
               state, livesLeft, dying, bus.moveResetN);
    end
    gameEnable = 1'b0;
    tick();
    resetN = 1'b1;
    tick();
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("[TB] FAIL after_reset: state=%0d expected 0", state);
    end
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    resetN           = 1'b0;
    startOfFrame     = 1'b0;
    gameEnable       = 1'b0;
    bus.leftPressed  = 1'b0;
    bus.rightPressed = 1'b0;
    bus.upPressed    = 1'b0;
    bus.downPressed  = 1'b0;
    bus.onRope       = 1'b0;
    bus.onLedge      = 1'b0;
    bus.enemyHit     = 1'b0;
    bus.topLeftY     = 11'sd100;
    #12;
    test_reset();
    test_jump();
    test_climb();
    test_death_respawn();
    test_game_over();
    test_hit_priority_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
